// File: rtl/ebpf_imm_decode.sv
// eBPF instruction-slot decoder: field split, LDDW two-slot merge,
// one-deep output register and slot-index tagging.
module ebpf_imm_decode #(
  parameter int         PC_W    = 16,
  parameter logic [7:0] LDDW_OP = 8'h18
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [63:0]     in_insn,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_opcode,
  output logic [3:0]      out_dst,
  output logic [3:0]      out_src,
  output logic [15:0]     out_off,
  output logic [31:0]     out_imm32,
  output logic [63:0]     out_imm64,
  output logic            out_is_lddw,
  output logic            out_err,
  output logic [PC_W-1:0] out_pc
);

  typedef enum logic {
    S_FIRST   = 1'b0,
    S_LDDW_HI = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic            out_valid_q, out_valid_d;
  logic [7:0]      opcode_q, opcode_d;
  logic [3:0]      dst_q, dst_d;
  logic [3:0]      src_q, src_d;
  logic [15:0]     off_q, off_d;
  logic [31:0]     imm32_q, imm32_d;
  logic [63:0]     imm64_q, imm64_d;
  logic            is_lddw_q, is_lddw_d;
  logic            err_q, err_d;
  logic [PC_W-1:0] pc_q, pc_d;

  logic [7:0]      lat_op_q, lat_op_d;
  logic [3:0]      lat_dst_q, lat_dst_d;
  logic [3:0]      lat_src_q, lat_src_d;
  logic [15:0]     lat_off_q, lat_off_d;
  logic [31:0]     lat_lo_q, lat_lo_d;
  logic [PC_W-1:0] lat_pc_q, lat_pc_d;

  logic [PC_W-1:0] slot_cnt_q, slot_cnt_d;

  logic [7:0]  s_op;
  logic [3:0]  s_dst;
  logic [3:0]  s_src;
  logic [15:0] s_off;
  logic [31:0] s_imm;
  logic        accept;

  assign s_op  = in_insn[7:0];
  assign s_dst = in_insn[11:8];
  assign s_src = in_insn[15:12];
  assign s_off = in_insn[31:16];
  assign s_imm = in_insn[63:32];

  assign in_ready = (!out_valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    opcode_d    = opcode_q;
    dst_d       = dst_q;
    src_d       = src_q;
    off_d       = off_q;
    imm32_d     = imm32_q;
    imm64_d     = imm64_q;
    is_lddw_d   = is_lddw_q;
    err_d       = err_q;
    pc_d        = pc_q;
    lat_op_d    = lat_op_q;
    lat_dst_d   = lat_dst_q;
    lat_src_d   = lat_src_q;
    lat_off_d   = lat_off_q;
    lat_lo_d    = lat_lo_q;
    lat_pc_d    = lat_pc_q;
    slot_cnt_d  = slot_cnt_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      slot_cnt_d = slot_cnt_q + PC_W'(1);
      case (state_q)
        S_FIRST: begin
          if (s_op == LDDW_OP) begin
            lat_op_d  = s_op;
            lat_dst_d = s_dst;
            lat_src_d = s_src;
            lat_off_d = s_off;
            lat_lo_d  = s_imm;
            lat_pc_d  = slot_cnt_q;
            state_d   = S_LDDW_HI;
          end else begin
            out_valid_d = 1'b1;
            opcode_d    = s_op;
            dst_d       = s_dst;
            src_d       = s_src;
            off_d       = s_off;
            imm32_d     = s_imm;
            imm64_d     = {32'h0, s_imm};
            is_lddw_d   = 1'b0;
            err_d       = 1'b0;
            pc_d        = slot_cnt_q;
          end
        end
        S_LDDW_HI: begin
          // Second slot must carry zero opcode/regs/offset
          out_valid_d = 1'b1;
          opcode_d    = lat_op_q;
          dst_d       = lat_dst_q;
          src_d       = lat_src_q;
          off_d       = lat_off_q;
          imm32_d     = lat_lo_q;
          imm64_d     = {s_imm, lat_lo_q};
          is_lddw_d   = 1'b1;
          err_d       = |in_insn[31:0];
          pc_d        = lat_pc_q;
          state_d     = S_FIRST;
        end
        default: state_d = S_FIRST;
      endcase
    end

    if (flush) begin
      state_d     = S_FIRST;
      out_valid_d = 1'b0;
      opcode_d    = '0;
      dst_d       = '0;
      src_d       = '0;
      off_d       = '0;
      imm32_d     = '0;
      imm64_d     = '0;
      is_lddw_d   = 1'b0;
      err_d       = 1'b0;
      pc_d        = '0;
      lat_op_d    = '0;
      lat_dst_d   = '0;
      lat_src_d   = '0;
      lat_off_d   = '0;
      lat_lo_d    = '0;
      lat_pc_d    = '0;
      slot_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_FIRST;
      out_valid_q <= 1'b0;
      opcode_q    <= '0;
      dst_q       <= '0;
      src_q       <= '0;
      off_q       <= '0;
      imm32_q     <= '0;
      imm64_q     <= '0;
      is_lddw_q   <= 1'b0;
      err_q       <= 1'b0;
      pc_q        <= '0;
      lat_op_q    <= '0;
      lat_dst_q   <= '0;
      lat_src_q   <= '0;
      lat_off_q   <= '0;
      lat_lo_q    <= '0;
      lat_pc_q    <= '0;
      slot_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      opcode_q    <= opcode_d;
      dst_q       <= dst_d;
      src_q       <= src_d;
      off_q       <= off_d;
      imm32_q     <= imm32_d;
      imm64_q     <= imm64_d;
      is_lddw_q   <= is_lddw_d;
      err_q       <= err_d;
      pc_q        <= pc_d;
      lat_op_q    <= lat_op_d;
      lat_dst_q   <= lat_dst_d;
      lat_src_q   <= lat_src_d;
      lat_off_q   <= lat_off_d;
      lat_lo_q    <= lat_lo_d;
      lat_pc_q    <= lat_pc_d;
      slot_cnt_q  <= slot_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_opcode  = opcode_q;
  assign out_dst     = dst_q;
  assign out_src     = src_q;
  assign out_off     = off_q;
  assign out_imm32   = imm32_q;
  assign out_imm64   = imm64_q;
  assign out_is_lddw = is_lddw_q;
  assign out_err     = err_q;
  assign out_pc      = pc_q;

endmodule

// File: tb/tb_ebpf_imm_decode.sv
// Bench for ebpf_imm_decode: vector table plus scoreboard of
// expected records, with back-pressure, flush, reset and PC wrap.
module tb_ebpf_imm_decode;

  localparam int PC_W = 4;

  typedef struct {
    logic [31:0] hdr;
    logic [63:0] imm64;
    logic        lddw;
    logic        err;
    logic [3:0]  pc;
  } rec_t;

  typedef struct {
    logic [63:0] insn;
    logic        emit;
    rec_t        rec;
  } vec_t;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [63:0]     in_insn = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [7:0]      out_opcode;
  logic [3:0]      out_dst;
  logic [3:0]      out_src;
  logic [15:0]     out_off;
  logic [31:0]     out_imm32;
  logic [63:0]     out_imm64;
  logic            out_is_lddw;
  logic            out_err;
  logic [PC_W-1:0] out_pc;

  int checks = 0;
  int failures = 0;
  rec_t sbq[$];
  vec_t tbl[7];
  rec_t none;

  ebpf_imm_decode #(.PC_W(PC_W), .LDDW_OP(8'h18)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_dst(out_dst), .out_src(out_src),
    .out_off(out_off), .out_imm32(out_imm32), .out_imm64(out_imm64),
    .out_is_lddw(out_is_lddw), .out_err(out_err), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  // Handshake seen at negedge completes on the following posedge
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      rec_t e;
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL rec_unexpected got pc=%0d imm64=%h",
                 out_pc, out_imm64);
      end else begin
        e = sbq.pop_front();
        if ({out_off, out_src, out_dst, out_opcode} !== e.hdr ||
            out_imm32 !== e.imm64[31:0] || out_imm64 !== e.imm64 ||
            out_is_lddw !== e.lddw || out_err !== e.err ||
            out_pc !== e.pc) begin
          failures++;
          $display("FAIL rec got hdr=%h imm32=%h imm64=%h l=%b e=%b pc=%0d exp hdr=%h imm64=%h l=%b e=%b pc=%0d",
                   {out_off, out_src, out_dst, out_opcode}, out_imm32,
                   out_imm64, out_is_lddw, out_err, out_pc,
                   e.hdr, e.imm64, e.lddw, e.err, e.pc);
        end
      end
    end
  end

  task automatic send(input logic [63:0] insn, input logic emit,
                      input rec_t r);
    bit done = 0;
    in_insn  = insn;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (emit) sbq.push_back(r);
        done = 1;
        break;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got in_ready=0 exp 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    none = '{32'h0, 64'h0, 1'b0, 1'b0, 4'd0};
    tbl[0] = '{64'hFFFF_FFFE_0000_0107, 1'b1,
               '{32'h0000_0107, 64'h0000_0000_FFFF_FFFE, 1'b0, 1'b0, 4'd0}};
    tbl[1] = '{64'h1234_5678_0010_3218, 1'b0, none};
    tbl[2] = '{64'hDEAD_BEEF_0000_0000, 1'b1,
               '{32'h0010_3218, 64'hDEAD_BEEF_1234_5678, 1'b1, 1'b0, 4'd1}};
    tbl[3] = '{64'h0000_0005_FFFC_54B7, 1'b1,
               '{32'hFFFC_54B7, 64'h0000_0000_0000_0005, 1'b0, 1'b0, 4'd3}};
    tbl[4] = '{64'hCAFE_0001_0000_0718, 1'b0, none};
    tbl[5] = '{64'h0000_0042_0000_0007, 1'b1,
               '{32'h0000_0718, 64'h0000_0042_CAFE_0001, 1'b1, 1'b1, 4'd4}};
    tbl[6] = '{64'h8000_0000_8000_FA61, 1'b1,
               '{32'h8000_FA61, 64'h0000_0000_8000_0000, 1'b0, 1'b0, 4'd6}};

    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_imm64", out_imm64, 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_lddw", 64'(out_is_lddw), 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) send(tbl[i].insn, tbl[i].emit, tbl[i].rec);

    // Back-pressure: A held while B waits
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(64'h0000_00AA_0002_2107, 1'b1,
         '{32'h0002_2107, 64'h0000_0000_0000_00AA, 1'b0, 1'b0, 4'd7});
    in_insn  = 64'h0000_00BB_0003_3107;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_imm64", out_imm64, 64'h0000_0000_0000_00AA);
      chk("bp_pc", 64'(out_pc), 64'd7);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    if (in_ready)
      sbq.push_back('{32'h0003_3107, 64'h0000_0000_0000_00BB,
                     1'b0, 1'b0, 4'd8});
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Flush while waiting for the LDDW high slot
    send(64'h1111_1111_0000_0018, 1'b0, none);
    in_insn  = 64'h0000_0099_0000_0007;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    send(64'h0000_0077_0000_0207, 1'b1,
         '{32'h0000_0207, 64'h0000_0000_0000_0077, 1'b0, 1'b0, 4'd0});

    // Reset while waiting for the LDDW high slot
    send(64'h2222_2222_0000_0018, 1'b0, none);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("rst2_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // PC wrap with a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      logic [31:0] v;
      v = 32'(i) + 32'h100;
      send({v, 32'h0000_0007}, 1'b1,
           '{32'h0000_0007, {32'h0, v}, 1'b0, 1'b0, 4'(i % 16)});
    end

    for (int i = 0; i < 20; i++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
    @(posedge clk); #1;
    chk("sb_drained", 64'(sbq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
